// File: rtl/mult_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
package mult_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/mult_abs.sv
// Conditional two's-complement negator: magnitude of operands
// and sign restoration of the product.
module mult_abs #(
    parameter int W = 32
) (
    input  logic         i_neg,
    input  logic [W-1:0] i_val,
    output logic [W-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/multiplier_seq.sv
// Iterative shift-add multiplier, signed or unsigned, with a
// start/busy/done handshake and a full 2*WIDTH-bit product.
module multiplier_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     in0,
    input  logic [WIDTH-1:0]     in1,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    localparam int CW = cnt_width(WIDTH);

    state_t               r_state;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CW-1:0]        r_cnt;
    logic                 r_neg;
    logic                 r_busy;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_result;

    logic                 w_neg0;
    logic                 w_neg1;
    logic [WIDTH-1:0]     w_mag0;
    logic [WIDTH-1:0]     w_mag1;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_hi;
    logic [2*WIDTH-1:0]   w_fixed;

    assign w_neg0 = signed_mode & in0[WIDTH-1];
    assign w_neg1 = signed_mode & in1[WIDTH-1];

    mult_abs #(.W(WIDTH)) u_abs0 (
        .i_neg (w_neg0),
        .i_val (in0),
        .o_val (w_mag0)
    );

    mult_abs #(.W(WIDTH)) u_abs1 (
        .i_neg (w_neg1),
        .i_val (in1),
        .o_val (w_mag1)
    );

    mult_abs #(.W(2*WIDTH)) u_fix (
        .i_neg (r_neg),
        .i_val (r_acc),
        .o_val (w_fixed)
    );

    // Upper half plus optional multiplicand; bit WIDTH is the carry.
    assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
    assign w_hi  = r_mplier[0] ? w_sum
                               : {1'b0, r_acc[2*WIDTH-1:WIDTH]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mcand  <= w_mag0;
                        r_mplier <= w_mag1;
                        r_neg    <= w_neg0 ^ w_neg1;
                        r_acc    <= '0;
                        r_cnt    <= CW'(WIDTH);
                        r_busy   <= 1'b1;
                        r_state  <= CALC;
                    end
                end
                CALC: begin
                    r_acc    <= {w_hi, r_acc[WIDTH-1:1]};
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    r_result <= w_fixed;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_multiplier_seq.sv
// Bench for multiplier_seq: WIDTH=32 and WIDTH=8 instances
// checked every cycle against an arithmetic reference model.
module tb_multiplier_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st [2];
    logic        sm [2];
    logic [31:0] a  [2];
    logic [31:0] b  [2];
    logic        bz0, dn0, bz1, dn1;
    logic [63:0] r0;
    logic [15:0] r1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    multiplier_seq #(.WIDTH(32)) u32 (
        .clk         (clk),
        .rst         (rst),
        .start       (st[0]),
        .signed_mode (sm[0]),
        .in0         (a[0]),
        .in1         (b[0]),
        .busy        (bz0),
        .done        (dn0),
        .result      (r0)
    );

    multiplier_seq #(.WIDTH(8)) u8 (
        .clk         (clk),
        .rst         (rst),
        .start       (st[1]),
        .signed_mode (sm[1]),
        .in0         (a[1][7:0]),
        .in1         (b[1][7:0]),
        .busy        (bz1),
        .done        (dn1),
        .result      (r1)
    );

    function automatic int wof(input int i);
        return (i == 0) ? 32 : 8;
    endfunction

    function automatic logic dbusy(input int i);
        return (i == 0) ? bz0 : bz1;
    endfunction

    function automatic logic ddone(input int i);
        return (i == 0) ? dn0 : dn1;
    endfunction

    function automatic logic [63:0] dres(input int i);
        return (i == 0) ? r0 : {48'b0, r1};
    endfunction

    // Exact product of w-bit operands, reduced modulo 2^(2w).
    function automatic logic [63:0] ref_mul(input int w, input logic s,
                                            input logic [31:0] x,
                                            input logic [31:0] y);
        longint lim;
        longint sx;
        longint sy;
        logic [63:0] p;
        lim = longint'(1) << w;
        sx  = longint'(x) & (lim - 1);
        sy  = longint'(y) & (lim - 1);
        if (s && sx >= lim / 2) sx = sx - lim;
        if (s && sy >= lim / 2) sy = sy - lim;
        p = 64'(sx * sy);
        if (w < 32) p = p & ((64'd1 << (2 * w)) - 64'd1);
        return p;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: cycles elapsed since the accepted start.
    int          age    [2];
    logic [63:0] prod   [2];
    logic [63:0] e_res  [2];
    logic        e_busy [2];
    logic        e_done [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                age[i]    = 0;
                e_busy[i] = 1'b0;
                e_done[i] = 1'b0;
                e_res[i]  = '0;
            end else begin
                e_done[i] = 1'b0;
                if (age[i] == 0) begin
                    if (st[i]) begin
                        prod[i]   = ref_mul(wof(i), sm[i], a[i], b[i]);
                        age[i]    = 1;
                        e_busy[i] = 1'b1;
                    end
                end else if (age[i] == wof(i) + 1) begin
                    e_res[i]  = prod[i];
                    e_done[i] = 1'b1;
                    e_busy[i] = 1'b0;
                    age[i]    = 0;
                end else begin
                    age[i]++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("busy%0d", i), 64'(dbusy(i)), 64'(e_busy[i]));
                chk($sformatf("done%0d", i), 64'(ddone(i)), 64'(e_done[i]));
                chk($sformatf("result%0d", i), dres(i), e_res[i]);
            end
        end
    end

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic do_op(input int i, input logic s,
                         input logic [31:0] x, input logic [31:0] y,
                         output logic [63:0] got, output int lat);
        st[i] = 1'b1;
        sm[i] = s;
        a[i]  = x;
        b[i]  = y;
        @(negedge clk);
        st[i] = 1'b0;
        lat   = 1;
        while (!ddone(i) && lat < 200) begin
            sm[i] = 1'($urandom);
            a[i]  = $urandom;
            b[i]  = $urandom;
            @(negedge clk);
            lat++;
        end
        if (!ddone(i)) begin
            errors++;
            $display("FAIL timeout dut%0d no done after %0d cycles", i, lat);
        end
        got = dres(i);
    endtask

    task automatic dir_op(input string nm, input int i, input logic s,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [63:0] exp);
        logic [63:0] got;
        int lat;
        do_op(i, s, x, y, got, lat);
        chk({nm, "_res"}, got, exp);
        chk({nm, "_lat"}, 64'(lat), 64'(wof(i) + 2));
    endtask

    initial begin
        logic [63:0] got;
        int lat;
        logic s;
        logic [31:0] x;
        logic [31:0] y;

        for (int i = 0; i < 2; i++) begin
            st[i] = 1'b0;
            sm[i] = 1'b0;
            a[i]  = '0;
            b[i]  = '0;
        end
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_busy", 64'(bz0), 64'd0);
        chk("rst_done", 64'(dn0), 64'd0);
        chk("rst_result", r0, 64'd0);
        rst = 1'b0;

        dir_op("u6x6", 0, 1'b0, 32'd6, 32'd6, 64'd36);
        dir_op("s_m5x3", 0, 1'b1, 32'hFFFF_FFFB, 32'd3,
               64'hFFFF_FFFF_FFFF_FFF1);
        dir_op("u_m5x3", 0, 1'b0, 32'hFFFF_FFFB, 32'd3,
               64'h0000_0002_FFFF_FFF1);
        dir_op("s_min2", 0, 1'b1, 32'h8000_0000, 32'h8000_0000,
               64'h4000_0000_0000_0000);
        dir_op("u_max2", 0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               64'hFFFF_FFFE_0000_0001);
        dir_op("zero", 0, 1'b1, 32'd0, 32'd5, 64'd0);

        // start held high with changing operands while busy
        @(negedge clk);
        st[0] = 1'b1;
        sm[0] = 1'b0;
        a[0]  = 32'd7;
        b[0]  = 32'd2;
        @(negedge clk);
        a[0]  = 32'd9;
        b[0]  = 32'd9;
        lat   = 1;
        while (!dn0 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        st[0] = 1'b0;
        chk("held_res", r0, 64'd14);
        chk("held_lat", 64'(lat), 64'd34);
        repeat (3) @(negedge clk);

        // back-to-back: second start issued in the done cycle
        dir_op("b2b_a", 0, 1'b0, 32'd15, 32'd1, 64'd15);
        dir_op("b2b_b", 0, 1'b0, 32'd4, 32'd4, 64'd16);

        // reset in the middle of CALC
        @(negedge clk);
        st[0] = 1'b1;
        a[0]  = 32'd5;
        b[0]  = 32'd5;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", 64'(bz0), 64'd0);
        chk("mid_rst_done", 64'(dn0), 64'd0);
        chk("mid_rst_res", r0, 64'd0);
        rst = 1'b0;
        dir_op("after_rst", 0, 1'b0, 32'd5, 32'd3, 64'd15);

        dir_op("w8_s", 1, 1'b1, 32'h80, 32'h80, 64'h4000);
        dir_op("w8_u", 1, 1'b0, 32'hFF, 32'hFF, 64'hFE01);
        for (int k = 0; k < 60; k++) begin
            s = 1'($urandom);
            x = $urandom;
            y = $urandom;
            do_op(1, s, x, y, got, lat);
            chk("w8_rand", got, ref_mul(8, s, x, y));
            chk("w8_lat", 64'(lat), 64'd10);
        end
        for (int k = 0; k < 12; k++) begin
            s = 1'($urandom);
            x = $urandom;
            y = $urandom;
            do_op(0, s, x, y, got, lat);
            chk("w32_rand", got, ref_mul(32, s, x, y));
        end

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
